i2c_target_regfile: RTL and testbench
=====================================

Name: i2c_target_regfile

Overview:
- Single-address I2C target (slave) that answers the existing I2C master over an open-drain SCL/SDA pair.
- Contains a DEPTH x 8 register file that the master writes and reads through an internal auto-incrementing register pointer.
- Supports repeated START and target-side clock stretching controlled by the local `stretch` input.
- Reports every register write and every byte load on local strobes so the host logic can track bus activity.

Parameters:
- DEV_ADDR, 7'h2A: 7-bit I2C target address.
- DEPTH, 16: number of 8-bit registers; must be a power of 2, 2..256.
- PW, 4: pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- scl_i  in  1  SCL line as seen on the bus, asynchronous.
- sda_i  in  1  SDA line as seen on the bus, asynchronous.
- scl_oe  out  1  1 = pull SCL low (stretch); 0 = release.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- stretch  in  1  local request to hold SCL low.
- busy  out  1  1 from an address match until STOP or NACK-release.
- wr_stb  out  1  one-cycle pulse when a data byte is written to the register file.
- wr_idx  out  PW  register index written, valid while wr_stb is high.
- wr_data  out  8  byte written, valid while wr_stb is high.
- rd_stb  out  1  one-cycle pulse when a byte is loaded for transmit.
- rd_idx  out  PW  register index loaded, valid while rd_stb is high.

Behaviour:
- **Input sampling**
  - scl_i and sda_i pass through 2-flop synchronizers.
  - Edges and START/STOP are detected on the synchronized values, so detection latency is 3 clk.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
  - Data is sampled on SCL rising edges. The target changes sda_oe only in the cycle after an SCL falling edge is detected.
- **Reset**
  - All outputs are 0; state is IDLE; pointer is 0; all registers are 0.
  - Reset mid-transfer releases SDA and SCL on the next clk.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
  - START from any state, including a repeated START, goes to ADDR with the bit counter cleared and sda_oe released.
  - STOP from any state goes to IDLE and clears busy. The pointer is retained across transactions.
- **ADDR**
  - Shifts in 8 bits: 7-bit address then R/W.
  - On match, ACK by setting sda_oe=1 from the 8th falling edge to the 9th falling edge, and set busy.
  - On mismatch, go to WAIT_STOP with sda_oe kept at 0.
- **Write (R/W=0)**
  - The first byte after the address is the register pointer; only its low PW bits are kept. It is ACKed (PTR_ACK).
  - Each later byte is ACKed and written to reg[ptr]. wr_stb pulses at the 8th rising-edge sample with wr_idx=ptr, then ptr increments modulo DEPTH.
- **Read (R/W=1)**
  - At the falling edge ending the address ACK, load reg[ptr] into the shift register, pulse rd_stb with rd_idx=ptr, increment ptr, and drive the MSB.
  - Each later falling edge drives the next bit; sda_oe = ~bit.
  - After the 8th falling edge, release SDA and sample the master's ACK on the 9th rising edge.
  - ACK (SDA=0): load the next byte at the 9th falling edge.
  - NACK (SDA=1): go to WAIT_STOP, keep SDA released, clear busy.
- **Clock stretching**
  - scl_oe asserts only when stretch=1, busy=1 and synchronized SCL is already low. It is never asserted while SCL is high.
  - scl_oe holds until stretch=0 and deasserts on the next clk.
  - The SDA value being driven is held stable while stretching.
- **Boundaries**
  - Pointer wraps DEPTH-1 → 0 for both reads and writes.
  - A write with only a pointer byte and no data updates ptr, with no wr_stb.
  - START during ADDR_ACK or RDATA aborts the current transfer; no partial register write occurs.
- **Latency**
  - ACK/data are driven 1 clk after an SCL falling edge is detected, i.e. 4 clk after the bus edge.
  - For a 40 MHz clk this gives valid setup at up to 400 kHz SCL.

Test Plan:
- **Write burst:** START, 0x54, 0x03, 0xA5, 0x3C, STOP → all 4 bytes ACKed; wr_stb twice, (idx 3, 0xA5) then (idx 4, 0x3C); busy falls after STOP.
- **Read with repeated START:** START, 0x54, 0x03, Sr, 0x55, read 2 bytes (ACK then NACK), STOP → data 0xA5 then 0x3C; rd_idx 3 then 4; sda_oe 0 after NACK.
- **Address mismatch:** START, 0x56, 0x11, STOP → no ACK (SDA high on the 9th clock), no strobes, busy stays 0.
- **Pointer wrap and masking:**
  - Write pointer 0x1F with data 0x11, 0x22 → wr_idx 15 then 0.
  - Read from pointer 0x0F returns 0x11, 0x22.
- **Stretch:** hold stretch=1 for 1200 clk after the address ACK of a read → scl_oe=1 within 4 clk of SCL low, no SDA change during the hold; byte read correctly after release.
- **Reset mid-read:** assert rst while driving bit 0 of a byte → next clk sda_oe=0, scl_oe=0, busy=0; a subsequent read of pointer 0 returns 0x00.

Source files
------------

// File: rtl/i2c_target_regfile_if.sv
// I2C target register file: open-drain bus pins plus local stretch control and
// activity strobes, grouped so the target and its environment share one bundle.
interface i2c_target_regfile_if #(
   parameter int PW = 4
);
   logic          scl_i;
   logic          sda_i;
   logic          scl_oe;
   logic          sda_oe;
   logic          stretch;
   logic          busy;
   logic          wr_stb;
   logic [PW-1:0] wr_idx;
   logic [7:0]    wr_data;
   logic          rd_stb;
   logic [PW-1:0] rd_idx;

   // target side
   modport slave (
      input  scl_i, sda_i, stretch,
      output scl_oe, sda_oe, busy, wr_stb, wr_idx, wr_data, rd_stb, rd_idx
   );

   // bus / host side
   modport master (
      output scl_i, sda_i, stretch,
      input  scl_oe, sda_oe, busy, wr_stb, wr_idx, wr_data, rd_stb, rd_idx
   );
endinterface

// File: rtl/i2c_target_regfile.sv
// Single-address I2C target with a DEPTH x 8 register file behind an
// auto-incrementing pointer. First written byte sets the pointer, later bytes
// are stored; reads stream registers out from the pointer. Supports repeated
// START and local clock stretching.
module i2c_target_regfile #(
   parameter logic [6:0] DEV_ADDR = 7'h2A,
   parameter int         DEPTH    = 16,
   parameter int         PW       = 4
) (
   input logic                 clk,
   input logic                 rst,
   i2c_target_regfile_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
   } state_t;

   logic [1:0]    scl_sync_q, sda_sync_q;
   logic          scl_prev_q, sda_prev_q;
   logic          scl_s, sda_s;
   logic          scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]    rx_byte;

   state_t        state_q;
   logic [3:0]    bitcnt_q;
   logic [7:0]    shift_q;
   logic          rw_q;
   logic [PW-1:0] ptr_q;
   logic [7:0]    regs_q [DEPTH];
   logic          sda_oe_q, scl_oe_q, busy_q;
   logic          wr_stb_q, rd_stb_q;
   logic [PW-1:0] wr_idx_q, rd_idx_q;
   logic [7:0]    wr_data_q;

   // Two-flop synchronizers plus one history flop for edge/condition detection.
   // Reset to 1 so an idle bus never looks like an edge after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[0], bus.scl_i};
         sda_sync_q <= {sda_sync_q[0], bus.sda_i};
         scl_prev_q <= scl_sync_q[1];
         sda_prev_q <= sda_sync_q[1];
      end
   end

   assign scl_s = scl_sync_q[1];
   assign sda_s = sda_sync_q[1];

   // Bus events; START/STOP need SCL high in both the current and previous sample.
   always_comb begin
      scl_rise  = scl_s & ~scl_prev_q;
      scl_fall  = ~scl_s & scl_prev_q;
      start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
      stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
      rx_byte   = {shift_q[6:0], sda_s};
   end

   // Protocol FSM, register file, pointer and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bitcnt_q  <= '0;
         shift_q   <= '0;
         rw_q      <= 1'b0;
         ptr_q     <= '0;
         sda_oe_q  <= 1'b0;
         scl_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_idx_q  <= '0;
         wr_data_q <= '0;
         rd_stb_q  <= 1'b0;
         rd_idx_q  <= '0;
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         wr_stb_q <= 1'b0;
         rd_stb_q <= 1'b0;
         // Only start pulling SCL once it is already low; hold until stretch drops.
         scl_oe_q <= bus.stretch & (scl_oe_q | (busy_q & ~scl_s));
         if (start_det) begin
            state_q  <= ADDR;
            bitcnt_q <= '0;
            sda_oe_q <= 1'b0;
         end else if (stop_det) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            sda_oe_q <= 1'b0;
         end else begin
            case (state_q)
               // Receive a byte (address, pointer or data), then ACK on the 8th fall.
               ADDR, PTR, WDATA: begin
                  if (scl_rise && bitcnt_q != 4'd8) begin
                     shift_q  <= rx_byte;
                     bitcnt_q <= bitcnt_q + 4'd1;
                     if (bitcnt_q == 4'd7 && state_q == PTR) ptr_q <= rx_byte[PW-1:0];
                     if (bitcnt_q == 4'd7 && state_q == WDATA) begin
                        regs_q[ptr_q] <= rx_byte;
                        wr_stb_q      <= 1'b1;
                        wr_idx_q      <= ptr_q;
                        wr_data_q     <= rx_byte;
                        ptr_q         <= ptr_q + PW'(1);
                     end
                  end else if (scl_fall && bitcnt_q == 4'd8) begin
                     if (state_q == ADDR && shift_q[7:1] != DEV_ADDR) begin
                        state_q <= WAIT_STOP;
                        busy_q  <= 1'b0;
                     end else begin
                        sda_oe_q <= 1'b1;
                        if (state_q == ADDR) begin
                           busy_q  <= 1'b1;
                           rw_q    <= shift_q[0];
                           state_q <= ADDR_ACK;
                        end else begin
                           state_q <= (state_q == PTR) ? PTR_ACK : WDATA_ACK;
                        end
                     end
                  end
               end
               // ACK slot we drove ends on the 9th fall.
               PTR_ACK, WDATA_ACK: begin
                  if (scl_fall) begin
                     sda_oe_q <= 1'b0;
                     bitcnt_q <= '0;
                     state_q  <= WDATA;
                  end
               end
               // End of address ACK, or master ACK slot after a read byte:
               // both may load the next byte to transmit.
               ADDR_ACK, RDATA_ACK: begin
                  if (scl_rise && state_q == RDATA_ACK) begin
                     if (sda_s) begin
                        state_q <= WAIT_STOP;
                        busy_q  <= 1'b0;
                     end else begin
                        bitcnt_q <= 4'd1;
                     end
                  end else if (scl_fall && (state_q == ADDR_ACK || bitcnt_q == 4'd1)) begin
                     bitcnt_q <= '0;
                     if (state_q == ADDR_ACK && !rw_q) begin
                        sda_oe_q <= 1'b0;
                        state_q  <= PTR;
                     end else begin
                        shift_q  <= regs_q[ptr_q];
                        sda_oe_q <= ~regs_q[ptr_q][7];
                        rd_stb_q <= 1'b1;
                        rd_idx_q <= ptr_q;
                        ptr_q    <= ptr_q + PW'(1);
                        state_q  <= RDATA;
                     end
                  end
               end
               // Shift the byte out MSB first; release SDA after the 8th bit.
               RDATA: begin
                  if (scl_rise) begin
                     bitcnt_q <= bitcnt_q + 4'd1;
                  end else if (scl_fall) begin
                     if (bitcnt_q == 4'd8) begin
                        sda_oe_q <= 1'b0;
                        bitcnt_q <= '0;
                        state_q  <= RDATA_ACK;
                     end else begin
                        sda_oe_q <= ~shift_q[6];
                        shift_q  <= {shift_q[6:0], 1'b0};
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.sda_oe  = sda_oe_q;
   assign bus.scl_oe  = scl_oe_q;
   assign bus.busy    = busy_q;
   assign bus.wr_stb  = wr_stb_q;
   assign bus.wr_idx  = wr_idx_q;
   assign bus.wr_data = wr_data_q;
   assign bus.rd_stb  = rd_stb_q;
   assign bus.rd_idx  = rd_idx_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged open-drain master, table of
// directed transactions, stretch and reset corner cases, then random
// transactions checked against a register-array reference model.
module tb_i2c_target_regfile;

   localparam logic [6:0] DEV   = 7'h2A;
   localparam int         DEPTH = 16;
   localparam int         PW    = 4;
   localparam int         Q     = 6;

   logic clk = 1'b0;
   logic rst;
   logic m_scl, m_sda, stretch_r;

   always #5 clk = ~clk;

   i2c_target_regfile_if #(.PW(PW)) bus ();

   assign bus.scl_i   = m_scl & ~bus.scl_oe;
   assign bus.sda_i   = m_sda & ~bus.sda_oe;
   assign bus.stretch = stretch_r;

   i2c_target_regfile #(.DEV_ADDR(DEV), .DEPTH(DEPTH), .PW(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [11:0] wr_log [$];
   logic [3:0]  rd_log [$];

   // reference model
   logic [7:0]  mem [DEPTH];
   int          mptr;
   logic [11:0] exp_wr [$];
   logic [7:0]  exp_rd_d [$];
   logic [3:0]  exp_rd_i [$];

   logic busy_mid, sda_after_nack;

   // strobe monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.wr_stb) wr_log.push_back({bus.wr_idx, bus.wr_data});
         if (bus.rd_stb) rd_log.push_back(bus.rd_idx);
      end
   end

   initial begin
      #950000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic scl_up();
      int t;
      m_scl = 1'b1;
      @(negedge clk);
      t = 1;
      while (bus.scl_i !== 1'b1 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (bus.scl_i !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL scl_release: got 0, expected 1");
      end
   endtask

   task automatic start_c();
      m_sda = 1'b1; wait_clk(Q);
      scl_up();     wait_clk(Q);
      m_sda = 1'b0; wait_clk(Q);
      m_scl = 1'b0; wait_clk(Q);
   endtask

   task automatic stop_c();
      m_sda = 1'b0; wait_clk(Q);
      scl_up();     wait_clk(Q);
      m_sda = 1'b1; wait_clk(Q);
   endtask

   task automatic write_bit(input logic b);
      m_sda = b;    wait_clk(Q);
      scl_up();     wait_clk(Q);
      m_scl = 1'b0; wait_clk(Q);
   endtask

   task automatic read_bit(output logic b);
      m_sda = 1'b1; wait_clk(Q);
      scl_up();     wait_clk(Q / 2);
      b = bus.sda_i;
      wait_clk(Q - Q / 2);
      m_scl = 1'b0; wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(nack);
   endtask

   // acks[0]=address, [1]=pointer, [2+i]=data i; 0 means ACK
   task automatic do_write(input logic [6:0] a, input logic [7:0] p, input int n,
                           input logic [31:0] dp, output logic [5:0] acks);
      logic b;
      acks = '0;
      start_c();
      write_byte({a, 1'b0}, b); acks[0] = b;
      busy_mid = bus.busy;
      write_byte(p, b); acks[1] = b;
      for (int i = 0; i < n; i++) begin
         write_byte(dp[8*i +: 8], b);
         acks[2+i] = b;
      end
      stop_c();
   endtask

   // acks[0]=write address, [1]=pointer, [2]=read address
   task automatic do_read(input logic [6:0] a, input logic [7:0] p, input int n,
                          input logic set_ptr, output logic [31:0] rd, output logic [5:0] acks);
      logic b;
      logic [7:0] d;
      acks = '0;
      rd   = '0;
      if (set_ptr) begin
         start_c();
         write_byte({a, 1'b0}, b); acks[0] = b;
         write_byte(p, b);         acks[1] = b;
      end
      start_c();
      write_byte({a, 1'b1}, b); acks[2] = b;
      busy_mid = bus.busy;
      for (int i = 0; i < n; i++) begin
         read_byte(i == n - 1, d);
         rd[8*i +: 8] = d;
      end
      sda_after_nack = bus.sda_oe;
      stop_c();
   endtask

   task automatic model_write(input logic [6:0] a, input logic [7:0] p, input int n,
                              input logic [31:0] dp);
      exp_wr.delete();
      if (a == DEV) begin
         mptr = p % DEPTH;
         for (int i = 0; i < n; i++) begin
            mem[mptr] = dp[8*i +: 8];
            exp_wr.push_back({4'(mptr), dp[8*i +: 8]});
            mptr = (mptr + 1) % DEPTH;
         end
      end
   endtask

   task automatic model_read(input logic [7:0] p, input logic set_ptr, input int n);
      exp_rd_d.delete();
      exp_rd_i.delete();
      if (set_ptr) mptr = p % DEPTH;
      for (int i = 0; i < n; i++) begin
         exp_rd_d.push_back(mem[mptr]);
         exp_rd_i.push_back(4'(mptr));
         mptr = (mptr + 1) % DEPTH;
      end
   endtask

   typedef struct {
      int          kind;   // 0 write, 1 pointer write + Sr + read, 2 read at current pointer
      logic [6:0]  addr;
      logic [7:0]  ptr;
      int          n;
      logic [31:0] d;
      logic        acked;
      int          nstb;
      logic [3:0]  idx0, idx1;
      logic [7:0]  dat0, dat1;
   } vec_t;

   vec_t tv [7];

   initial begin
      logic [5:0]  acks, amask;
      logic [31:0] rd;
      logic [11:0] got, want;
      logic [7:0]  d;
      logic        b, s0;
      int          bad, kind, n, t;
      logic [6:0]  a;
      logic [7:0]  p;
      logic [31:0] dp;

      tv[0] = '{0, DEV,   8'h03, 2, 32'h3CA5, 1'b1, 2, 4'd3,  4'd4, 8'hA5, 8'h3C};
      tv[1] = '{1, DEV,   8'h03, 2, 32'h0,    1'b1, 2, 4'd3,  4'd4, 8'hA5, 8'h3C};
      tv[2] = '{0, 7'h2B, 8'h11, 0, 32'h0,    1'b0, 0, 4'd0,  4'd0, 8'h00, 8'h00};
      tv[3] = '{0, DEV,   8'h1F, 2, 32'h2211, 1'b1, 2, 4'd15, 4'd0, 8'h11, 8'h22};
      tv[4] = '{1, DEV,   8'h0F, 2, 32'h0,    1'b1, 2, 4'd15, 4'd0, 8'h11, 8'h22};
      tv[5] = '{0, DEV,   8'h07, 0, 32'h0,    1'b1, 0, 4'd0,  4'd0, 8'h00, 8'h00};
      tv[6] = '{2, DEV,   8'h00, 1, 32'h0,    1'b1, 1, 4'd7,  4'd0, 8'h00, 8'h00};

      for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
      mptr = 0;

      m_scl = 1'b1; m_sda = 1'b1; stretch_r = 1'b0; rst = 1'b1;
      wait_clk(4);
      check("reset_sda_oe", bus.sda_oe, 0);
      check("reset_scl_oe", bus.scl_oe, 0);
      check("reset_busy",   bus.busy,   0);
      check("reset_strobes", {bus.wr_stb, bus.rd_stb}, 0);
      rst = 1'b0;
      wait_clk(4);

      // directed table
      for (int v = 0; v < 7; v++) begin
         wr_log.delete();
         rd_log.delete();
         if (tv[v].kind == 0) begin
            do_write(tv[v].addr, tv[v].ptr, tv[v].n, tv[v].d, acks);
            model_write(tv[v].addr, tv[v].ptr, tv[v].n, tv[v].d);
            amask = 6'((1 << (tv[v].n + 2)) - 1);
            check($sformatf("v%0d_acks", v), 32'(acks & amask), tv[v].acked ? 32'd0 : 32'(amask));
            check($sformatf("v%0d_wr_cnt", v), wr_log.size(), tv[v].nstb);
            check($sformatf("v%0d_rd_cnt", v), rd_log.size(), 0);
            for (int k = 0; k < tv[v].nstb; k++) begin
               got  = (k < wr_log.size()) ? wr_log[k] : 12'hxxx;
               want = (k == 0) ? {tv[v].idx0, tv[v].dat0} : {tv[v].idx1, tv[v].dat1};
               check($sformatf("v%0d_wr%0d", v, k), got, want);
            end
         end else begin
            do_read(tv[v].addr, tv[v].ptr, tv[v].n, tv[v].kind == 1, rd, acks);
            model_read(tv[v].ptr, tv[v].kind == 1, tv[v].n);
            check($sformatf("v%0d_acks", v), acks, 0);
            check($sformatf("v%0d_rd_cnt", v), rd_log.size(), tv[v].nstb);
            for (int k = 0; k < tv[v].n; k++) begin
               check($sformatf("v%0d_rdata%0d", v, k), rd[8*k +: 8],
                     (k == 0) ? tv[v].dat0 : tv[v].dat1);
               check($sformatf("v%0d_rd_idx%0d", v, k),
                     (k < rd_log.size()) ? rd_log[k] : 4'hx, (k == 0) ? tv[v].idx0 : tv[v].idx1);
            end
            check($sformatf("v%0d_sda_after_nack", v), sda_after_nack, 0);
         end
         check($sformatf("v%0d_busy_mid", v), busy_mid, tv[v].acked);
         wait_clk(2);
         check($sformatf("v%0d_busy_after_stop", v), bus.busy, 0);
      end

      // clock stretch after the address ACK of a read
      wr_log.delete();
      rd_log.delete();
      start_c();
      write_byte({DEV, 1'b0}, b);
      write_byte(8'h03, b);
      start_c();
      write_byte({DEV, 1'b1}, b);
      check("stretch_addr_ack", b, 0);
      model_read(8'h03, 1'b1, 1);
      stretch_r = 1'b1;
      t = 0;
      while (bus.scl_oe !== 1'b1 && t < 4) begin
         wait_clk(1);
         t++;
      end
      check("stretch_assert", bus.scl_oe, 1);
      s0  = bus.sda_oe;
      bad = 0;
      for (int i = 0; i < 1200; i++) begin
         wait_clk(1);
         if (bus.scl_oe !== 1'b1 || bus.sda_oe !== s0 || bus.scl_i !== 1'b0) bad++;
      end
      check("stretch_hold", bad, 0);
      stretch_r = 1'b0;
      wait_clk(2);
      check("stretch_release", bus.scl_oe, 0);
      read_byte(1'b1, d);
      stop_c();
      check("stretch_rdata", d, exp_rd_d[0]);
      check("stretch_rd_idx", (rd_log.size() > 0) ? rd_log[0] : 4'hx, exp_rd_i[0]);

      // reset while driving bit 0 of a read byte
      do_write(DEV, 8'h00, 1, 32'h5A, acks);
      model_write(DEV, 8'h00, 1, 32'h5A);
      start_c();
      write_byte({DEV, 1'b0}, b);
      write_byte(8'h00, b);
      start_c();
      write_byte({DEV, 1'b1}, b);
      for (int i = 0; i < 7; i++) read_bit(b);
      check("rst_pre_sda_oe", bus.sda_oe, 1);
      rst = 1'b1;
      wait_clk(1);
      check("rst_sda_oe", bus.sda_oe, 0);
      check("rst_scl_oe", bus.scl_oe, 0);
      check("rst_busy",   bus.busy,   0);
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
      mptr = 0;
      m_sda = 1'b1;
      m_scl = 1'b1;
      wait_clk(Q);
      do_read(DEV, 8'h00, 1, 1'b1, rd, acks);
      model_read(8'h00, 1'b1, 1);
      check("rst_read_acks", acks, 0);
      check("rst_read_data", rd[7:0], 8'h00);

      // random transactions against the model
      for (int it = 0; it < 24; it++) begin
         wr_log.delete();
         rd_log.delete();
         kind = $urandom_range(0, 2);
         p    = 8'($urandom);
         dp   = $urandom;
         if (kind == 0) begin
            n = $urandom_range(0, 3);
            a = ($urandom_range(0, 4) == 0) ? 7'($urandom) : DEV;
            if (a != DEV && $urandom_range(0, 1) == 0) a = DEV ^ 7'h01;
            do_write(a, p, n, dp, acks);
            model_write(a, p, n, dp);
            amask = 6'((1 << (n + 2)) - 1);
            check($sformatf("r%0d_acks", it), 32'(acks & amask), (a == DEV) ? 32'd0 : 32'(amask));
            check($sformatf("r%0d_wr_cnt", it), wr_log.size(), exp_wr.size());
            for (int k = 0; k < exp_wr.size(); k++)
               check($sformatf("r%0d_wr%0d", it, k),
                     (k < wr_log.size()) ? wr_log[k] : 12'hxxx, exp_wr[k]);
         end else begin
            n = $urandom_range(1, 3);
            do_read(DEV, p, n, kind == 1, rd, acks);
            model_read(p, kind == 1, n);
            check($sformatf("r%0d_acks", it), acks, 0);
            check($sformatf("r%0d_rd_cnt", it), rd_log.size(), exp_rd_i.size());
            for (int k = 0; k < n; k++) begin
               check($sformatf("r%0d_rdata%0d", it, k), rd[8*k +: 8], exp_rd_d[k]);
               check($sformatf("r%0d_rd_idx%0d", it, k),
                     (k < rd_log.size()) ? rd_log[k] : 4'hx, exp_rd_i[k]);
            end
         end
         wait_clk(2);
         check($sformatf("r%0d_busy_idle", it), bus.busy, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
